// File: rtl/lsu_pkg.sv
// Shared definitions for the M-stage load/store unit: funct3 encodings,
// the board address map, region/size enums and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] ADDR_LEDR = 32'h0000_7000;
    localparam logic [31:0] ADDR_LEDG = 32'h0000_7010;
    localparam logic [31:0] ADDR_HEXL = 32'h0000_7020;
    localparam logic [31:0] ADDR_HEXH = 32'h0000_7024;
    localparam logic [31:0] ADDR_LCD  = 32'h0000_7030;
    localparam logic [31:0] ADDR_SW   = 32'h0000_7800;
    localparam logic [31:0] ADDR_BTN  = 32'h0000_7810;

    typedef enum logic [3:0] {
        REG_DMEM, REG_LEDR, REG_LEDG, REG_HEXL, REG_HEXH,
        REG_LCD, REG_SW, REG_BTN, REG_NONE
    } region_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    // Unlisted funct3 values fall back to a full word access.
    function automatic size_e decode_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    // I/O registers match on the word address so byte/half accesses
    // inside a register word hit that register.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] dmem_base,
                                              input logic [31:0] dmem_end);
        logic [31:0] wa;
        wa = {addr[31:2], 2'b00};
        if (addr >= dmem_base && addr < dmem_end) return REG_DMEM;
        case (wa)
            ADDR_LEDR: return REG_LEDR;
            ADDR_LEDG: return REG_LEDG;
            ADDR_HEXL: return REG_HEXL;
            ADDR_HEXH: return REG_HEXH;
            ADDR_LCD:  return REG_LCD;
            ADDR_SW:   return REG_SW;
            ADDR_BTN:  return REG_BTN;
            default:   return REG_NONE;
        endcase
    endfunction

    // Replace only the enabled byte lanes of a word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-enabled data memory: DEPTH x 32-bit words, synchronous write,
// asynchronous read so loads resolve in the same cycle.
module lsu_dmem #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem [DEPTH];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = mem[i_addr];

endmodule

// File: rtl/lsu_mem_stage.sv
// M-stage load/store unit: address decode, byte-enabled stores to data
// memory and board I/O registers, extended same-cycle loads.
// Optional macro LSU_IO_SYNC_EN: puts switches/buttons behind a two-flop
// synchronizer; otherwise they are read straight from the pins.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int          DMEM_DEPTH = 2048,
    parameter logic [31:0] DMEM_BASE  = 32'h0000_2000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [2:0]  i_funct3,
    input  logic        i_lsu_wren,
    input  logic [17:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic [31:0] o_ld_data,
    output logic [16:0] o_io_ledr,
    output logic [7:0]  o_io_ledg,
    output logic [55:0] o_io_hex,
    output logic [31:0] o_io_lcd,
    output logic        o_misaligned
);

    localparam int          IDXW     = $clog2(DMEM_DEPTH);
    localparam logic [31:0] DMEM_END = DMEM_BASE + (32'(DMEM_DEPTH) << 2);

    size_e       size;
    region_e     region;
    logic        misaligned;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_word;
    logic [31:0] merged;
    logic [31:0] dmem_rdata;
    logic [31:0] dmem_offset;
    logic [IDXW-1:0] dmem_idx;
    logic        dmem_unused;
    logic        store_ok;
    logic        dmem_we;
    logic [16:0] ledr;
    logic [7:0]  ledg;
    logic [27:0] hex_lo;
    logic [27:0] hex_hi;
    logic [31:0] lcd;
    logic [17:0] sw_s;
    logic [3:0]  btn_s;

    // Decode access size, target region and alignment.
    always_comb begin
        size       = decode_size(i_funct3);
        region     = decode_region(i_lsu_addr, DMEM_BASE, DMEM_END);
        misaligned = ((size == SZ_H) && i_lsu_addr[0]) ||
                     ((size == SZ_W) && (i_lsu_addr[1:0] != 2'b00));
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        be    = 4'b0000;
        wdata = i_st_data;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << i_lsu_addr[1:0];
                wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_st_data[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    assign store_ok    = i_lsu_wren && !misaligned;
    assign dmem_we     = store_ok && (region == REG_DMEM) && !i_rst;
    assign dmem_offset = i_lsu_addr - DMEM_BASE;
    assign dmem_idx    = dmem_offset[IDXW+1:2];
    assign dmem_unused = ^{dmem_offset[31:IDXW+2], dmem_offset[1:0]};

    lsu_dmem #(
        .DEPTH (DMEM_DEPTH)
    ) u_dmem (
        .i_clk   (i_clk),
        .i_we    (dmem_we),
        .i_be    (be),
        .i_addr  (dmem_idx),
        .i_wdata (wdata),
        .o_rdata (dmem_rdata)
    );

`ifdef LSU_IO_SYNC_EN
    logic [17:0] sw_meta;
    logic [3:0]  btn_meta;

    // Two-flop synchronizer for the asynchronous board inputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sw_meta  <= '0;
            sw_s     <= '0;
            btn_meta <= '0;
            btn_s    <= '0;
        end else begin
            sw_meta  <= i_io_sw;
            sw_s     <= sw_meta;
            btn_meta <= i_io_btn;
            btn_s    <= btn_meta;
        end
    end
`else
    assign sw_s  = i_io_sw;
    assign btn_s = i_io_btn;
`endif

    // Current 32-bit word of the addressed region, zero-padded.
    always_comb begin
        rd_word = '0;
        case (region)
            REG_DMEM: rd_word = dmem_rdata;
            REG_LEDR: rd_word = {15'd0, ledr};
            REG_LEDG: rd_word = {24'd0, ledg};
            REG_HEXL: rd_word = {4'd0, hex_lo};
            REG_HEXH: rd_word = {4'd0, hex_hi};
            REG_LCD:  rd_word = lcd;
            REG_SW:   rd_word = {14'd0, sw_s};
            REG_BTN:  rd_word = {28'd0, btn_s};
            default:  rd_word = '0;
        endcase
    end

    assign merged = merge_bytes(rd_word, wdata, be);

    // Board output registers: partial writes merge into the current value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ledr   <= '0;
            ledg   <= '0;
            hex_lo <= '0;
            hex_hi <= '0;
            lcd    <= '0;
        end else if (store_ok) begin
            case (region)
                REG_LEDR: ledr   <= merged[16:0];
                REG_LEDG: ledg   <= merged[7:0];
                REG_HEXL: hex_lo <= merged[27:0];
                REG_HEXH: hex_hi <= merged[27:0];
                REG_LCD:  lcd    <= merged;
                default:  ;
            endcase
        end
    end

    // Lane extract and sign/zero extension of load data.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel  = rd_word[{i_lsu_addr[1:0], 3'b000} +: 8];
        half_sel  = i_lsu_addr[1] ? rd_word[31:16] : rd_word[15:0];
        o_ld_data = '0;
        if (!misaligned) begin
            case (i_funct3)
                F3_B:    o_ld_data = {{24{byte_sel[7]}}, byte_sel};
                F3_BU:   o_ld_data = {24'd0, byte_sel};
                F3_H:    o_ld_data = {{16{half_sel[15]}}, half_sel};
                F3_HU:   o_ld_data = {16'd0, half_sel};
                default: o_ld_data = rd_word;
            endcase
        end
    end

    assign o_misaligned = misaligned;
    assign o_io_ledr    = ledr;
    assign o_io_ledg    = ledg;
    assign o_io_hex     = {hex_hi, hex_lo};
    assign o_io_lcd     = lcd;

endmodule
